// File: rtl/gaa_pop_writer.sv
// gaa_pop_writer: packs HPS population bytes into 16-bit words and streams them into SDRAM from word 0.
// Optional COUNT register word counter is built when GAA_POP_WRITER_COUNT_EN is defined.
module gaa_pop_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  hps_address,
  input  logic        hps_chipselect,
  input  logic        hps_write,
  input  logic        hps_read,
  input  logic [7:0]  hps_writedata,
  output logic [7:0]  hps_readdata,
  output logic        hps_waitrequest,
  output logic [24:0] sdram_address,
  output logic [1:0]  sdram_byteenable_n,
  output logic        sdram_chipselect,
  output logic        sdram_write_n,
  output logic [15:0] sdram_writedata,
  input  logic        sdram_waitrequest
);

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned OCC_W  = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  be_n;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [0:0]         state_q, state_d;
  logic               pend_q, pend_d;
  logic [7:0]         pend_byte_q, pend_byte_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic               cs_q, cs_d, wrn_q, wrn_d;
  logic [1:0]         be_n_q, be_n_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic [7:0]         count_rd;

  logic               wr_data, wr_ctrl, clr_req, flush_req, push_req, full;
  logic               data_acc, push, pop, clear;
  logic [PTR_W-1:0]   rd_nxt;
  entry_t             push_entry;

  assign wr_data   = hps_chipselect & hps_write & (hps_address == REG_DATA);
  assign wr_ctrl   = hps_chipselect & hps_write & (hps_address == REG_CTRL);
  assign clr_req   = wr_ctrl & hps_writedata[0];
  assign flush_req = wr_ctrl & ~hps_writedata[0] & hps_writedata[1] & pend_q;
  assign push_req  = (wr_data & pend_q) | flush_req;
  assign full      = (occ_q == OCC_W'(DEPTH));

  // Stall HPS while a push would hit a full FIFO or a clear arrives mid-write
  assign hps_waitrequest = ~reset | (push_req & full) | (clr_req & (state_q == ST_WRITE));

  assign data_acc = wr_data & ~hps_waitrequest;
  assign push     = push_req & ~hps_waitrequest;
  assign clear    = clr_req & ~hps_waitrequest;
  assign pop      = (state_q == ST_WRITE) & ~sdram_waitrequest;
  assign rd_nxt   = rd_q + PTR_W'(1);

  always_comb begin
    push_entry.data = {8'h00, pend_byte_q};
    push_entry.be_n = 2'b10;
    if (wr_data) begin
      push_entry.data = {hps_writedata, pend_byte_q};
      push_entry.be_n = 2'b00;
    end
  end

`ifdef GAA_POP_WRITER_COUNT_EN
  logic [7:0] wcnt_q, wcnt_d;
  assign count_rd = wcnt_q;
`else
  assign count_rd = 8'h00;
`endif

  // Byte packing, FIFO bookkeeping and master FSM next-state
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    occ_d       = occ_q;
    wptr_d      = wptr_q;
    cs_d        = cs_q;
    wrn_d       = wrn_q;
    be_n_d      = be_n_q;
    addr_d      = addr_q;
    data_d      = data_q;
`ifdef GAA_POP_WRITER_COUNT_EN
    wcnt_d      = wcnt_q;
`endif

    if (clear) begin
      pend_d = 1'b0;
    end else if (data_acc) begin
      pend_d = ~pend_q;
      if (!pend_q) pend_byte_d = hps_writedata;
    end else if (push) begin
      pend_d = 1'b0;
    end

    if (clear) begin
      rd_d   = '0;
      wr_d   = '0;
      occ_d  = '0;
      wptr_d = '0;
`ifdef GAA_POP_WRITER_COUNT_EN
      wcnt_d = 8'h00;
`endif
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_nxt;
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    case (state_q)
      ST_IDLE: begin
        if (!clear && (occ_q != '0)) begin
          state_d = ST_WRITE;
          cs_d    = 1'b1;
          wrn_d   = 1'b0;
          addr_d  = wptr_q;
          data_d  = mem_q[rd_q].data;
          be_n_d  = mem_q[rd_q].be_n;
        end
      end
      default: begin
        if (pop) begin
          wptr_d = wptr_q + ADDR_W'(1);
`ifdef GAA_POP_WRITER_COUNT_EN
          wcnt_d = wcnt_q + 8'd1;
`endif
          if (occ_q > OCC_W'(1)) begin
            addr_d = wptr_q + ADDR_W'(1);
            data_d = mem_q[rd_nxt].data;
            be_n_d = mem_q[rd_nxt].be_n;
          end else begin
            state_d = ST_IDLE;
            cs_d    = 1'b0;
            wrn_d   = 1'b1;
            be_n_d  = 2'b11;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
      rd_q        <= '0;
      wr_q        <= '0;
      occ_q       <= '0;
      wptr_q      <= '0;
      cs_q        <= 1'b0;
      wrn_q       <= 1'b1;
      be_n_q      <= 2'b11;
      addr_q      <= '0;
      data_q      <= 16'h0000;
`ifdef GAA_POP_WRITER_COUNT_EN
      wcnt_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      occ_q       <= occ_d;
      wptr_q      <= wptr_d;
      cs_q        <= cs_d;
      wrn_q       <= wrn_d;
      be_n_q      <= be_n_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef GAA_POP_WRITER_COUNT_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  // FIFO storage needs no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_entry;
  end

  always_comb begin
    hps_readdata = 8'h00;
    if (reset && hps_chipselect && hps_read) begin
      case (hps_address)
        REG_STATUS: hps_readdata = {5'b0, pend_q, full, (occ_q == '0) && (state_q == ST_IDLE)};
        REG_COUNT:  hps_readdata = count_rd;
        default:    hps_readdata = 8'h00;
      endcase
    end
  end

  assign sdram_address      = addr_q;
  assign sdram_byteenable_n = be_n_q;
  assign sdram_chipselect   = cs_q;
  assign sdram_write_n      = wrn_q;
  assign sdram_writedata    = data_q;

endmodule

// File: tb/tb_gaa_pop_writer.sv
// Directed bench for gaa_pop_writer: scoreboard of expected SDRAM writes checked by a bus monitor.
module tb_gaa_pop_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  hps_address = 2'd0;
  logic        hps_chipselect = 1'b0, hps_write = 1'b0, hps_read = 1'b0;
  logic [7:0]  hps_writedata = 8'h00;
  logic [7:0]  hps_readdata;
  logic        hps_waitrequest;
  logic [24:0] sdram_address;
  logic [1:0]  sdram_byteenable_n;
  logic        sdram_chipselect, sdram_write_n;
  logic [15:0] sdram_writedata;
  logic        sdram_waitrequest = 1'b0;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be_n;
  } xfer_t;

`ifdef GAA_POP_WRITER_COUNT_EN
  localparam logic [7:0] CNT4 = 8'h04;
`else
  localparam logic [7:0] CNT4 = 8'h00;
`endif

  xfer_t       exp_q[$];
  int          checks = 0, errors = 0, xfer_cnt = 0;
  logic [24:0] exp_addr = '0;

  gaa_pop_writer dut (
    .clk(clk), .reset(rst_n),
    .hps_address(hps_address), .hps_chipselect(hps_chipselect),
    .hps_write(hps_write), .hps_read(hps_read),
    .hps_writedata(hps_writedata), .hps_readdata(hps_readdata),
    .hps_waitrequest(hps_waitrequest),
    .sdram_address(sdram_address), .sdram_byteenable_n(sdram_byteenable_n),
    .sdram_chipselect(sdram_chipselect), .sdram_write_n(sdram_write_n),
    .sdram_writedata(sdram_writedata), .sdram_waitrequest(sdram_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Completed SDRAM writes are compared against the scoreboard in order
  always @(negedge clk) begin
    xfer_t e;
    if (rst_n && sdram_chipselect && !sdram_write_n && !sdram_waitrequest) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(sdram_address), 64'(e.addr));
        chk("wr_data", 64'(sdram_writedata), 64'(e.data));
        chk("wr_be_n", 64'(sdram_byteenable_n), 64'(e.be_n));
      end
    end
  end

  task automatic hps_wr(input logic [1:0] a, input logic [7:0] d, output int stall);
    int n = 0;
    hps_address = a; hps_writedata = d; hps_chipselect = 1'b1; hps_write = 1'b1;
    @(negedge clk);
    while (hps_waitrequest === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("hps_wr_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    hps_chipselect = 1'b0; hps_write = 1'b0;
    stall = n;
  endtask

  task automatic hps_rd(input logic [1:0] a, output logic [7:0] d);
    hps_address = a; hps_chipselect = 1'b1; hps_read = 1'b1;
    @(negedge clk);
    d = hps_readdata;
    @(posedge clk); #1;
    hps_chipselect = 1'b0; hps_read = 1'b0;
  endtask

  task automatic wait_idle(output logic [7:0] st);
    st = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      hps_rd(2'd2, st);
      if (st == 8'h01) break;
    end
  endtask

  task automatic put_word(input logic [7:0] lo, input logic [7:0] hi);
    int s;
    exp_q.push_back('{addr: exp_addr, data: {hi, lo}, be_n: 2'b00});
    exp_addr = exp_addr + 25'd1;
    hps_wr(2'd0, lo, s);
    hps_wr(2'd0, hi, s);
  endtask

  task automatic do_clear();
    int s;
    hps_wr(2'd1, 8'h01, s);
    exp_addr = '0;
  endtask

  initial begin
    int          st;
    int          x0;
    logic [7:0]  rd;

    // Reset values, with a STATUS read held on the bus
    hps_address = 2'd2; hps_chipselect = 1'b1; hps_read = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cs", 64'(sdram_chipselect), 64'd0);
    chk("rst_write_n", 64'(sdram_write_n), 64'd1);
    chk("rst_be_n", 64'(sdram_byteenable_n), 64'd3);
    chk("rst_addr", 64'(sdram_address), 64'd0);
    chk("rst_wdata", 64'(sdram_writedata), 64'd0);
    chk("rst_readdata", 64'(hps_readdata), 64'd0);
    chk("rst_waitreq", 64'(hps_waitrequest), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; hps_chipselect = 1'b0; hps_read = 1'b0;
    @(negedge clk);
    chk("post_rst_waitreq", 64'(hps_waitrequest), 64'd0);
    @(posedge clk); #1;
    hps_rd(2'd2, rd);
    chk("status_reset", 64'(rd), 64'h01);

    // Two bytes form one word at address 0
    x0 = xfer_cnt;
    put_word(8'h12, 8'h34);
    wait_idle(rd);
    chk("status_after_word", 64'(rd), 64'h01);
    chk("one_write", 64'(xfer_cnt - x0), 64'd1);

    // Odd byte flushed as a low-lane-only write
    hps_wr(2'd0, 8'hAB, st);
    hps_rd(2'd2, rd);
    chk("status_pending", 64'(rd), 64'h05);
    exp_q.push_back('{addr: exp_addr, data: 16'h00AB, be_n: 2'b10});
    exp_addr = exp_addr + 25'd1;
    hps_wr(2'd1, 8'h02, st);
    wait_idle(rd);
    chk("status_after_flush", 64'(rd), 64'h01);
    x0 = xfer_cnt;
    hps_wr(2'd1, 8'h02, st);
    repeat (4) @(posedge clk);
    #1;
    chk("flush_noop", 64'(xfer_cnt - x0), 64'd0);
    hps_rd(2'd2, rd);
    chk("flush_noop_status", 64'(rd), 64'h01);

    // Backpressure: five words with SDRAM stalled, fifth stalls the HPS
    do_clear();
    sdram_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) put_word(8'h10 + 8'(2*i), 8'h11 + 8'(2*i));
    hps_wr(2'd0, 8'h18, st);
    hps_rd(2'd2, rd);
    chk("status_full", 64'(rd), 64'h06);
    exp_q.push_back('{addr: exp_addr, data: 16'h1918, be_n: 2'b00});
    exp_addr = exp_addr + 25'd1;
    fork
      hps_wr(2'd0, 8'h19, st);
      begin
        repeat (5) @(negedge clk);
        chk("stall_waitreq", 64'(hps_waitrequest), 64'd1);
        chk("stall_addr", 64'(sdram_address), 64'd0);
        chk("stall_data", 64'(sdram_writedata), 64'h1110);
        chk("stall_strobes", 64'({sdram_chipselect, sdram_write_n}), 64'b10);
        @(posedge clk); #1;
        sdram_waitrequest = 1'b0;
      end
    join
    chk("stall_seen", 64'(st >= 5), 64'd1);
    wait_idle(rd);
    chk("status_after_stall", 64'(rd), 64'h01);
    chk("sb_empty_stall", 64'(exp_q.size()), 64'd0);

    // Four queued words drain on consecutive cycles
    do_clear();
    sdram_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) put_word(8'hA0 + 8'(i), 8'hB0 + 8'(i));
    sdram_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_strobes", 64'({sdram_chipselect, sdram_write_n}), 64'b10);
    end
    @(negedge clk);
    chk("burst_end_cs", 64'(sdram_chipselect), 64'd0);
    @(posedge clk); #1;
    hps_rd(2'd3, rd);
    chk("count_four", 64'(rd), 64'(CNT4));

    // Clear during a stalled write waits for the write to finish
    do_clear();
    sdram_waitrequest = 1'b1;
    put_word(8'h55, 8'h66);
    repeat (2) @(posedge clk);
    #1;
    fork
      hps_wr(2'd1, 8'h01, st);
      begin
        repeat (3) @(negedge clk);
        chk("clear_stall", 64'(hps_waitrequest), 64'd1);
        @(posedge clk); #1;
        sdram_waitrequest = 1'b0;
      end
    join
    exp_addr = '0;
    chk("clear_stalled", 64'(st >= 3), 64'd1);
    hps_rd(2'd3, rd);
    chk("count_cleared", 64'(rd), 64'h00);
    put_word(8'h77, 8'h88);
    wait_idle(rd);
    chk("sb_empty_clear", 64'(exp_q.size()), 64'd0);

    // Reset mid-write aborts the transfer at once
    sdram_waitrequest = 1'b1;
    put_word(8'h99, 8'hAA);
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_cs", 64'(sdram_chipselect), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", 64'(sdram_chipselect), 64'd0);
    chk("abort_write_n", 64'(sdram_write_n), 64'd1);
    chk("abort_waitreq", 64'(hps_waitrequest), 64'd1);
    void'(exp_q.pop_back());
    exp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sdram_waitrequest = 1'b0;
    @(negedge clk);
    chk("rerelease_waitreq", 64'(hps_waitrequest), 64'd0);
    @(posedge clk); #1;
    hps_rd(2'd2, rd);
    chk("status_after_abort", 64'(rd), 64'h01);
    put_word(8'hC3, 8'h3C);
    wait_idle(rd);
    chk("status_final", 64'(rd), 64'h01);
    chk("sb_empty_final", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gaa_pop_writer.md
GAA_POP_WRITER -- requirements
Module: gaa_pop_writer

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL have ports: hps_address  input  2  slave register select (0 DATA, 1 CTRL, 2 STATUS, 3 COUNT).
REQ-004 SHALL have ports: hps_chipselect, hps_write, hps_read  input  1 each  Avalon MM slave strobes.
REQ-005 SHALL have ports: hps_writedata  input  8  write data; hps_readdata  output  8  read data; hps_waitrequest  output  1  slave stall.
REQ-006 SHALL have ports: sdram_address  output  25  word address; sdram_byteenable_n  output  2  active-low byte lanes; sdram_chipselect  output  1; sdram_write_n  output  1  active-low write.
REQ-007 SHALL have ports: sdram_writedata  output  16  write data; sdram_waitrequest  input  1  master stall.

Function
REQ-008 Block SHALL load population bytes from the HPS into SDRAM, starting at word 0, for the downstream fitness stage to read.
REQ-009 Write to DATA with no byte pending SHALL latch byte as low byte and set pending.
REQ-010 Write to DATA with byte pending SHALL form word {new byte, pending byte}, byteenable_n 2'b00, push into FIFO, and clear pending.
REQ-011 FIFO SHALL be 4 entries of {16-bit data, 2-bit byteenable_n}; push accepted only when occupancy before the edge is below 4; simultaneous pop does not free space that cycle.
REQ-012 hps_waitrequest SHALL be 1 combinationally while a DATA or flush write would push into a full FIFO; the write completes on the first edge with space.
REQ-013 CTRL write bit1 (flush) with byte pending SHALL push {8'h00, pending} with byteenable_n 2'b10; without a pending byte it is a no-op.
REQ-014 CTRL write bit0 (clear) SHALL stall via hps_waitrequest while master FSM is in WRITE; accepted in IDLE, it empties FIFO, drops pending byte, zeroes write pointer and word counter; clear has priority over flush in the same write.
REQ-015 Reads SHALL be zero-wait: STATUS = {5'b0, pending, full, idle}, idle = FIFO empty and FSM IDLE; COUNT per REQ-023; DATA/CTRL read 8'h00.
REQ-016 Master FSM states: IDLE, WRITE. IDLE with FIFO non-empty SHALL present head entry at write pointer (chipselect 1, write_n 0) and go to WRITE next edge.
REQ-017 In WRITE, all master outputs SHALL hold stable while sdram_waitrequest is 1.
REQ-018 On an edge in WRITE with sdram_waitrequest 0: pop head, write pointer +1, counter +1; if FIFO still non-empty after the pop, present next entry with no idle cycle, else deassert (chipselect 0, write_n 1, byteenable_n 2'b11) and return to IDLE.
REQ-019 Write pointer SHALL be 25-bit and wrap 25'h1FFFFFF -> 0 with no error.
REQ-020 Word counter SHALL be 8-bit and wrap 8'hFF -> 8'h00.

Reset
REQ-021 While reset is 0: FIFO empty, pending 0, pointer 0, counter 0, FSM IDLE, sdram_chipselect 0, sdram_write_n 1, sdram_byteenable_n 2'b11, sdram_address 0, sdram_writedata 0, hps_readdata 0, hps_waitrequest 1.
REQ-022 Reset assertion mid-transfer SHALL abort the SDRAM write immediately; after release, hps_waitrequest is 0 unless REQ-012/REQ-014 apply.

Configuration
REQ-023 Macro GAA_POP_WRITER_COUNT_EN: defined -> word counter built and COUNT reads its value; undefined -> no counter logic, COUNT reads 8'h00, all other behaviour unchanged.

Verification
REQ-024 Write DATA 8'h12 then 8'h34, sdram_waitrequest 0 -> one SDRAM write, address 0, data 16'h3412, byteenable_n 2'b00; STATUS idle=1 after.
REQ-025 Write DATA 8'hAB, CTRL 8'h02 -> SDRAM write data 16'h00AB, byteenable_n 2'b10; STATUS pending=0.
REQ-026 Hold sdram_waitrequest 1, write 10 DATA bytes -> 5th word stalls hps_waitrequest until release; 5 writes at addresses 0-4 in order, outputs stable during stall.
REQ-027 Four back-to-back words with waitrequest 0 -> four consecutive write cycles, no idle gap; with macro defined COUNT reads 8'h04.
REQ-028 CTRL 8'h01 issued during a stalled write -> hps_waitrequest 1 until write completes; next word goes to address 0, COUNT 8'h00.
REQ-029 Pull reset low mid-write -> same edge chipselect 0, write_n 1, hps_waitrequest 1.
